// File: rtl/ctrl_decoder.sv
// Instruction decoder FSM driving registered datapath mux selects over a valid/ready fetch handshake.
// Optional retired-instruction counter enabled by defining CTRL_DECODER_PERF_CNT_EN.
module ctrl_decoder #(
    parameter int IW  = 9,
    parameter int OPW = 3,
    parameter int FW  = 6
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    output logic          instr_ready,
    input  logic          flush,
    input  logic          zero_flag,
    output logic          mem_rd,
    output logic          ctrl_valid,
    output logic          Format,
    output logic          Load,
    output logic          ALUSrc,
    output logic          Branch,
    output logic          Copy,
    output logic          Move,
    output logic          BranchResult,
    output logic [FW-1:0] Field,
    output logic          halted
`ifdef CTRL_DECODER_PERF_CNT_EN
    ,
    output logic [15:0]   retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_BR,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_LD   = 3'b010,
        OP_ST   = 3'b011,
        OP_CPY  = 3'b100,
        OP_MOV  = 3'b101,
        OP_BEQ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    // Bit positions inside the packed select vector
    localparam int SEL_FORMAT = 6;
    localparam int SEL_LOAD   = 5;
    localparam int SEL_ALUSRC = 4;
    localparam int SEL_BRANCH = 3;
    localparam int SEL_COPY   = 2;
    localparam int SEL_MOVE   = 1;
    localparam int SEL_BRRES  = 0;

    state_t        state_q, state_d;
    logic [6:0]    sel_q, sel_d;
    logic          ctrl_valid_q, ctrl_valid_d;
    logic          mem_rd_q, mem_rd_d;
    logic [FW-1:0] field_q, field_d;
    logic          halted_q, halted_d;
    logic          accept;
    opcode_t       opcode;

    assign opcode      = opcode_t'(instr[IW-1 -: OPW]);
    assign instr_ready = (state_q == S_IDLE) && !flush;
    assign accept      = instr_valid && instr_ready;

    function automatic logic [6:0] single_cycle_sel(input opcode_t op);
        logic [6:0] s;
        s = '0;
        unique case (op)
            OP_ADDI, OP_ST: begin
                s[SEL_FORMAT] = 1'b1;
                s[SEL_ALUSRC] = 1'b1;
            end
            OP_CPY:  s[SEL_COPY] = 1'b1;
            OP_MOV:  s[SEL_MOVE] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        sel_d        = '0;
        ctrl_valid_d = 1'b0;
        mem_rd_d     = 1'b0;
        field_d      = field_q;
        halted_d     = halted_q;

        unique case (state_q)
            S_IDLE: begin
                field_d = '0;
                if (accept) begin
                    field_d = instr[FW-1:0];
                    unique case (opcode)
                        OP_LD: begin
                            state_d  = S_MEM;
                            mem_rd_d = 1'b1;
                        end
                        OP_BEQ: state_d = S_BR;
                        OP_HALT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            field_d  = '0;
                        end
                        default: begin
                            state_d      = S_EXEC;
                            ctrl_valid_d = 1'b1;
                            sel_d        = single_cycle_sel(opcode);
                        end
                    endcase
                end
            end
            S_MEM: begin
                state_d          = S_EXEC;
                ctrl_valid_d     = 1'b1;
                sel_d[SEL_LOAD]  = 1'b1;
            end
            S_BR: begin
                state_d           = S_EXEC;
                ctrl_valid_d      = 1'b1;
                sel_d[SEL_BRANCH] = 1'b1;
                sel_d[SEL_BRRES]  = zero_flag;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                field_d = '0;
            end
            S_HALT: begin
                halted_d = 1'b1;
                field_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                field_d = '0;
            end
        endcase

        // Flush overrides everything except a retired HALT
        if (flush && (state_q != S_HALT)) begin
            state_d      = S_IDLE;
            sel_d        = '0;
            ctrl_valid_d = 1'b0;
            mem_rd_d     = 1'b0;
            field_d      = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            ctrl_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            field_q      <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ctrl_valid_q <= ctrl_valid_d;
            mem_rd_q     <= mem_rd_d;
            field_q      <= field_d;
            halted_q     <= halted_d;
        end
    end

`ifdef CTRL_DECODER_PERF_CNT_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;
    logic        retire;

    // Counted on the same edge that raises ctrl_valid or enters S_HALT
    assign retire        = ctrl_valid_d || ((state_d == S_HALT) && (state_q != S_HALT));
    assign retired_cnt_d = retired_cnt_q + {15'd0, retire};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

    assign mem_rd       = mem_rd_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign Format       = sel_q[SEL_FORMAT];
    assign Load         = sel_q[SEL_LOAD];
    assign ALUSrc       = sel_q[SEL_ALUSRC];
    assign Branch       = sel_q[SEL_BRANCH];
    assign Copy         = sel_q[SEL_COPY];
    assign Move         = sel_q[SEL_MOVE];
    assign BranchResult = sel_q[SEL_BRRES];
    assign Field        = field_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Directed, table-driven bench for ctrl_decoder plus hand sequences for reset, flush and HALT.
module tb_ctrl_decoder;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       flush;
    logic       zero_flag;
    logic       mem_rd;
    logic       ctrl_valid;
    logic       Format, Load, ALUSrc, Branch, Copy, Move, BranchResult;
    logic [5:0] Field;
    logic       halted;
`ifdef CTRL_DECODER_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif
    logic [6:0] sel_act;

    assign sel_act = {Format, Load, ALUSrc, Branch, Copy, Move, BranchResult};

    ctrl_decoder #(.IW(9), .OPW(3), .FW(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .flush(flush), .zero_flag(zero_flag),
        .mem_rd(mem_rd), .ctrl_valid(ctrl_valid), .Format(Format), .Load(Load),
        .ALUSrc(ALUSrc), .Branch(Branch), .Copy(Copy), .Move(Move),
        .BranchResult(BranchResult), .Field(Field), .halted(halted)
`ifdef CTRL_DECODER_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one instruction at the next negedge; returns #1 after the accepting edge
    task automatic issue(input logic [8:0] ins);
        int unsigned n;
        n = 0;
        @(negedge Clk);
        while (!instr_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [8:0]  ins;
        logic        zf;
        int unsigned lat;      // cycles from accept to ctrl_valid
        logic        is_ld;
        logic [6:0]  sel;      // {Format,Load,ALUSrc,Branch,Copy,Move,BranchResult}
        logic [5:0]  field;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{9'b000_001010, 1'b0, 1, 1'b0, 7'b0000000, 6'h0A}; // ADD
        vecs[1] = '{9'b001_000101, 1'b0, 1, 1'b0, 7'b1010000, 6'h05}; // ADDI
        vecs[2] = '{9'b010_000011, 1'b0, 2, 1'b1, 7'b0100000, 6'h03}; // LD
        vecs[3] = '{9'b011_111111, 1'b0, 1, 1'b0, 7'b1010000, 6'h3F}; // ST
        vecs[4] = '{9'b100_010101, 1'b0, 1, 1'b0, 7'b0000100, 6'h15}; // CPY
        vecs[5] = '{9'b101_101010, 1'b0, 1, 1'b0, 7'b0000010, 6'h2A}; // MOV
        vecs[6] = '{9'b110_000111, 1'b1, 2, 1'b0, 7'b0001001, 6'h07}; // BEQ taken
        vecs[7] = '{9'b110_001000, 1'b0, 2, 1'b0, 7'b0001000, 6'h08}; // BEQ not taken

        Reset_n = 1'b0; instr_valid = 1'b0; instr = '0; flush = 1'b0; zero_flag = 1'b0;
        #12;
        chk("rst_ctrl_valid", 32'(ctrl_valid), 0);
        chk("rst_sel", 32'(sel_act), 0);
        chk("rst_field", 32'(Field), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_ready", 32'(instr_ready), 1);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        chk("idle_ready", 32'(instr_ready), 1);
        chk("idle_cv", 32'(ctrl_valid), 0);

        foreach (vecs[i]) begin
            zero_flag = ~vecs[i].zf;
            issue(vecs[i].ins);
            if (vecs[i].lat == 2) begin
                zero_flag = vecs[i].zf;
                chk($sformatf("v%0d_mid_cv", i), 32'(ctrl_valid), 0);
                chk($sformatf("v%0d_mid_memrd", i), 32'(mem_rd), 32'(vecs[i].is_ld));
                chk($sformatf("v%0d_mid_sel", i), 32'(sel_act), 0);
                chk($sformatf("v%0d_mid_ready", i), 32'(instr_ready), 0);
                step();
                zero_flag = ~vecs[i].zf;
            end
            chk($sformatf("v%0d_cv", i), 32'(ctrl_valid), 1);
            chk($sformatf("v%0d_sel", i), 32'(sel_act), 32'(vecs[i].sel));
            chk($sformatf("v%0d_field", i), 32'(Field), 32'(vecs[i].field));
            chk($sformatf("v%0d_memrd", i), 32'(mem_rd), 0);
            step();
            chk($sformatf("v%0d_after_cv", i), 32'(ctrl_valid), 0);
            chk($sformatf("v%0d_after_sel", i), 32'(sel_act), 0);
            chk($sformatf("v%0d_after_field", i), 32'(Field), 0);
            chk($sformatf("v%0d_after_ready", i), 32'(instr_ready), 1);
        end

        // Reset asserted while in S_MEM
        issue(9'b010_000011);
        chk("memrst_memrd_pre", 32'(mem_rd), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("memrst_memrd", 32'(mem_rd), 0);
        chk("memrst_field", 32'(Field), 0);
        chk("memrst_cv", 32'(ctrl_valid), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        chk("memrst_no_cv", 32'(ctrl_valid), 0);
        chk("memrst_no_load", 32'(Load), 0);
        chk("memrst_ready", 32'(instr_ready), 1);

        // Flush during S_BR suppresses the branch
        issue(9'b110_000001);
        zero_flag = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        zero_flag = 1'b0;
        #1;
        chk("brflush_cv", 32'(ctrl_valid), 0);
        chk("brflush_branch", 32'(Branch), 0);
        chk("brflush_ready", 32'(instr_ready), 1);
        step();
        chk("brflush_cv2", 32'(ctrl_valid), 0);

        // Flush with instr_valid in S_IDLE: flush wins
        @(negedge Clk);
        flush = 1'b1; instr_valid = 1'b1; instr = 9'b001_000101;
        #1;
        chk("idleflush_ready", 32'(instr_ready), 0);
        step();
        flush = 1'b0; instr_valid = 1'b0;
        chk("idleflush_cv", 32'(ctrl_valid), 0);
        chk("idleflush_sel", 32'(sel_act), 0);
        step();
        chk("idleflush_cv2", 32'(ctrl_valid), 0);
        chk("idleflush_ready2", 32'(instr_ready), 1);

        // Fresh reset, then 3 ADD + HALT
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(9'b000_000001);
            chk($sformatf("add%0d_cv", k), 32'(ctrl_valid), 1);
            step();
        end
        issue(9'b111_000000);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_ready", 32'(instr_ready), 0);
        chk("halt_cv", 32'(ctrl_valid), 0);
        flush = 1'b1;
        #1;
        chk("halt_ready_flush", 32'(instr_ready), 0);
        step();
        step();
        flush = 1'b0;
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_ready_after", 32'(instr_ready), 0);
`ifdef CTRL_DECODER_PERF_CNT_EN
        chk("retired_cnt", 32'(retired_cnt), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
